// File: rtl/scope_capture_buffer_if.sv
// Signal bundle between the scope capture buffer and its neighbours:
// sample stream and frame sync in, column read port and capture status out.
interface scope_capture_buffer_if #(
  parameter int DATA_W = 12
);
  logic signed [DATA_W-1:0] cordic_val;
  logic                     frame_start;
  logic [9:0]               rd_x;
  logic [8:0]               rd_y;
  logic                     rd_valid;
  logic                     capture_done;
  logic                     triggered;

  modport master (
    output cordic_val, frame_start, rd_x,
    input  rd_y, rd_valid, capture_done, triggered
  );

  modport slave (
    input  cordic_val, frame_start, rd_x,
    output rd_y, rd_valid, capture_done, triggered
  );
endinterface

// File: rtl/scope_capture_buffer.sv
// Decimates the signed sample stream, triggers on a rising zero crossing and
// stores one screen row per column; the trace stays frozen until the next frame.
module scope_capture_buffer #(
  parameter int DATA_W       = 12,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int CENTER_ROW   = 240,
  parameter int DECIM        = 320,
  parameter int TRIG_TIMEOUT = 2048
) (
  input  logic                   clk100,
  input  logic                   reset,
  scope_capture_buffer_if.slave  bus
);
  localparam int ADDR_W = $clog2(H_ACTIVE);
  localparam int DEC_W  = $clog2(DECIM);
  localparam int TO_W   = $clog2(TRIG_TIMEOUT + 1);
  localparam int RW     = DATA_W + 2;
  localparam logic signed [RW-1:0] CENTER_S  = RW'(CENTER_ROW);
  localparam logic signed [RW-1:0] ROW_MAX_S = RW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {ARM, TRIG, CAPTURE, HOLD} state_t;

  state_t              state, state_n;
  logic [DEC_W-1:0]    decim_cnt;
  logic                tick;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_n, waddr;
  logic [TO_W-1:0]     timeout_cnt, timeout_n;
  logic                prev_neg, prev_neg_n;
  logic                triggered_q, triggered_n;
  logic                rd_valid_q, rd_valid_n;
  logic                done_q, done_n;
  logic                we;
  logic                cur_neg;
  logic signed [RW-1:0] row_full;
  logic [8:0]          row;
  logic [8:0]          rd_y_q;
  logic [8:0]          ram [H_ACTIVE];

  assign tick    = (decim_cnt == DEC_W'(DECIM - 1));
  assign cur_neg = bus.cordic_val[DATA_W-1];

  // Row grows downwards on screen, so positive samples map above the centre line.
  assign row_full = CENTER_S - $signed({{2{bus.cordic_val[DATA_W-1]}}, bus.cordic_val});

  always_comb begin
    if (row_full[RW-1])             row = '0;
    else if (row_full > ROW_MAX_S)  row = 9'(V_ACTIVE - 1);
    else                            row = row_full[8:0];
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n     = state;
    wr_addr_n   = wr_addr;
    timeout_n   = timeout_cnt;
    prev_neg_n  = prev_neg;
    triggered_n = triggered_q;
    rd_valid_n  = rd_valid_q;
    done_n      = 1'b0;
    we          = 1'b0;
    waddr       = wr_addr;
    unique case (state)
      ARM: if (tick) begin
        prev_neg_n = cur_neg;
        timeout_n  = '0;
        state_n    = TRIG;
      end
      TRIG: if (tick) begin
        if ((prev_neg && !cur_neg) || timeout_cnt == TO_W'(TRIG_TIMEOUT - 1)) begin
          we          = 1'b1;
          waddr       = '0;
          wr_addr_n   = ADDR_W'(1);
          triggered_n = prev_neg && !cur_neg;
          state_n     = CAPTURE;
        end else begin
          timeout_n  = timeout_cnt + 1'b1;
          prev_neg_n = cur_neg;
        end
      end
      CAPTURE: if (tick) begin
        we = 1'b1;
        if (wr_addr == ADDR_W'(H_ACTIVE - 1)) begin
          done_n     = 1'b1;
          rd_valid_n = 1'b1;
          state_n    = HOLD;
        end else begin
          wr_addr_n = wr_addr + 1'b1;
        end
      end
      HOLD: if (bus.frame_start) begin
        rd_valid_n = 1'b0;
        state_n    = ARM;
      end
      default: state_n = ARM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100) begin
    if (!reset) begin
      state       <= ARM;
      decim_cnt   <= '0;
      wr_addr     <= '0;
      timeout_cnt <= '0;
      prev_neg    <= 1'b0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      decim_cnt   <= tick ? '0 : decim_cnt + 1'b1;
      wr_addr     <= wr_addr_n;
      timeout_cnt <= timeout_n;
      prev_neg    <= prev_neg_n;
      triggered_q <= triggered_n;
      rd_valid_q  <= rd_valid_n;
      done_q      <= done_n;
    end
  end

  // NOTE: the trace RAM has no reset so it maps onto block RAM; rd_valid guards stale contents.
  always_ff @(posedge clk100) begin
    if (reset && we) ram[waddr] <= row;
  end

  // Reading the old word on a same-address write only occurs while rd_valid is low.
  always_ff @(posedge clk100) begin
    if (!reset)                          rd_y_q <= '0;
    else if (bus.rd_x >= 10'(H_ACTIVE))  rd_y_q <= 9'(CENTER_ROW);
    else                                 rd_y_q <= ram[bus.rd_x[ADDR_W-1:0]];
  end

  assign bus.rd_y         = rd_y_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.capture_done = done_q;
  assign bus.triggered    = triggered_q;
endmodule

// File: tb/tb_scope_capture_buffer.sv
// Bench for scope_capture_buffer: directed and randomized traces checked against
// a trace-level model built from the decimated sample list.
module tb_scope_capture_buffer;
  localparam int DATA_W       = 12;
  localparam int H_ACTIVE     = 64;
  localparam int V_ACTIVE     = 480;
  localparam int CENTER_ROW   = 240;
  localparam int DECIM        = 4;
  localparam int TRIG_TIMEOUT = 32;
  localparam int BUDGET       = (TRIG_TIMEOUT + H_ACTIVE + 8) * DECIM;

  logic clk100 = 1'b0;
  logic reset  = 1'b0;
  always #5 clk100 = ~clk100;

  scope_capture_buffer_if #(.DATA_W(DATA_W)) bus ();

  scope_capture_buffer #(
    .DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .CENTER_ROW(CENTER_ROW), .DECIM(DECIM), .TRIG_TIMEOUT(TRIG_TIMEOUT)
  ) dut (
    .clk100(clk100),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: samples seen on decimation ticks since the last arm.
  int edge_n = 0;
  int q[$];
  bit m_hold = 0, m_valid = 0, m_done = 0, m_trig = 0;
  int trace[H_ACTIVE];
  int cur_v  = 0;
  int cur_x  = 0;
  int sine_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int row_of(input int v);
    int r;
    r = CENTER_ROW - v;
    if (r < 0) return 0;
    if (r > V_ACTIVE - 1) return V_ACTIVE - 1;
    return r;
  endfunction

  // Index of the first stored sample within q, or 0 if the trace has not started yet.
  function automatic bit trace_start(output int k, output bit trig);
    k = 0;
    trig = 0;
    for (int j = 1; j < q.size() && j <= TRIG_TIMEOUT; j++)
      if (q[j-1] < 0 && q[j] >= 0) begin
        k = j;
        trig = 1;
        return 1;
      end
    if (q.size() > TRIG_TIMEOUT) begin
      k = TRIG_TIMEOUT;
      return 1;
    end
    return 0;
  endfunction

  task automatic model_edge(input bit fs);
    int k;
    bit trig;
    m_done = 0;
    if (!reset) begin
      edge_n = 0;
      q.delete();
      m_hold = 0;
      m_valid = 0;
      m_trig = 0;
      return;
    end
    edge_n++;
    if (m_hold) begin
      if (fs) begin
        m_hold = 0;
        m_valid = 0;
        q.delete();
      end
      return;
    end
    if (edge_n % DECIM != 0) return;
    q.push_back(cur_v);
    if (trace_start(k, trig) && q.size() == k + H_ACTIVE) begin
      for (int i = 0; i < H_ACTIVE; i++) trace[i] = row_of(q[k+i]);
      m_hold = 1;
      m_valid = 1;
      m_done = 1;
      m_trig = trig;
    end
  endtask

  task automatic step(input bit fs);
    @(negedge clk100);
    bus.cordic_val  = DATA_W'(cur_v);
    bus.frame_start = fs;
    bus.rd_x        = 10'(cur_x);
    @(posedge clk100);
    model_edge(fs);
    #1;
    check("capture_done", bus.capture_done, m_done);
    check("rd_valid", bus.rd_valid, m_valid);
  endtask

  task automatic next_val(input int mode);
    case (mode)
      1: begin
        cur_v = $rtoi($floor(127.0 * $sin(6.283185307 * real'(sine_n) / 125.0) + 0.5));
        sine_n++;
      end
      2: cur_v = int'($urandom_range(600)) - 300;
      default: ;
    endcase
  endtask

  // Holds v until exactly one decimation tick has sampled it.
  task automatic tick_drive(input int v);
    cur_v = v;
    step(0);
    while (edge_n % DECIM != 0) step(0);
  endtask

  task automatic run_until_hold(input int mode, input string tag, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < BUDGET) begin
      next_val(mode);
      step(0);
      n++;
      if (bus.capture_done === 1'b1) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_triggered"}, bus.triggered, m_trig);
  endtask

  task automatic read_check(input int x, input string tag);
    cur_x = x;
    step(0);
    check(tag, bus.rd_y, (x >= H_ACTIVE) ? CENTER_ROW : trace[x]);
  endtask

  initial begin
    int n, k;
    bit trig;
    bus.cordic_val  = '0;
    bus.frame_start = 1'b0;
    bus.rd_x        = '0;

    // Reset held three clocks with a non-zero input.
    reset = 1'b0;
    cur_v = 55;
    repeat (3) step(0);
    check("reset_rd_y", bus.rd_y, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_done", bus.capture_done, 0);
    check("reset_triggered", bus.triggered, 0);
    reset = 1'b1;

    // Step -5 -> +5 on a tick boundary triggers a real capture.
    repeat (3) tick_drive(-5);
    tick_drive(5);
    run_until_hold(0, "step", n);
    check("step_latency", n, (H_ACTIVE - 1) * DECIM);
    check("step_triggered_const", bus.triggered, 1);
    cur_x = 0;
    step(0);
    check("step_col0_const", bus.rd_y, 235);
    foreach (trace[x]) read_check(x, "step_col");

    // Frame start in HOLD re-arms; a constant positive input only times out.
    step(1);
    check("rearm_valid_low", bus.rd_valid, 0);
    cur_v = 100;
    run_until_hold(0, "timeout", n);
    check("timeout_triggered_const", bus.triggered, 0);
    for (int x = 0; x < H_ACTIVE; x++) begin
      read_check(x, "timeout_col");
      check("timeout_col_const", bus.rd_y, 140);
    end

    // Clamping at both rails, plus a frame start pulsed mid-capture.
    step(1);
    repeat (3) tick_drive(-1);
    tick_drive(2047);
    tick_drive(-2048);
    tick_drive(127);
    tick_drive(-128);
    repeat (5) begin next_val(2); tick_drive(cur_v); end
    step(1);
    check("capture_ignores_frame_start", bus.rd_valid, 0);
    run_until_hold(2, "clamp", n);
    cur_x = 0; step(0); check("clamp_c0", bus.rd_y, 0);
    cur_x = 1; step(0); check("clamp_c1", bus.rd_y, 479);
    cur_x = 2; step(0); check("clamp_c2", bus.rd_y, 113);
    cur_x = 3; step(0); check("clamp_c3", bus.rd_y, 368);
    cur_x = 700; step(0); check("clamp_out_of_range", bus.rd_y, 240);
    foreach (trace[x]) read_check(x, "clamp_col");

    // Sine with reset pulsed mid-capture: abort, re-arm, clean trace.
    step(1);
    sine_n = int'($urandom_range(124));
    n = 0;
    while (n < BUDGET) begin
      next_val(1);
      step(0);
      n++;
      if (trace_start(k, trig) && q.size() >= k + 10) break;
    end
    check("sine_reached_capture", n < BUDGET, 1);
    reset = 1'b0;
    repeat (2) begin next_val(1); step(0); end
    check("sine_abort_rd_y", bus.rd_y, 0);
    check("sine_abort_triggered", bus.triggered, 0);
    reset = 1'b1;
    run_until_hold(1, "sine", n);
    foreach (trace[x]) read_check(x, "sine_col");

    // Random traces with random read columns, in and out of range.
    repeat (3) begin
      step(1);
      run_until_hold(2, "rand", n);
      repeat (24) read_check(int'($urandom_range(1023)), "rand_col");
      repeat (8) read_check(int'($urandom_range(H_ACTIVE - 1)), "rand_col_in");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
